// File: rtl/cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// cla_adder_pipe
//   Pipelined carry-lookahead adder/subtractor for partial-product
//   accumulation in the systolic-array MUL datapath. The operand is split
//   into 4-bit lookahead groups; groups ripple their carry to each other and
//   a register cut is placed after every GROUPS_PER_STAGE groups. Each stage
//   register carries the running carry, the sum bits already produced and the
//   operand bits still to be added, so all bits of a result leave together.
//
// Parameters
//   WIDTH            operand/sum width, multiple of 4, >= 4
//   GROUPS_PER_STAGE 4-bit groups evaluated per pipeline stage, >= 1
//   Latency = ceil((WIDTH/4)/GROUPS_PER_STAGE) cycles.
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle (combinational)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result
//   cout       carry-out (add) / NOT borrow (sub)
//   ovf        signed two's-complement overflow
// ---------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_GROUPS = WIDTH / 4;
  localparam int NUM_STAGES = (NUM_GROUPS + GROUPS_PER_STAGE - 1) / GROUPS_PER_STAGE;
  localparam int STAGE_BITS = 4 * GROUPS_PER_STAGE;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipeline moves as one: it advances whenever the output slot is
  // empty or being consumed, bubbles included.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Subtraction is a + ~b + ~cin, i.e. a - b - cin modulo 2^WIDTH.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = cin ^ sub;

  // Two-level lookahead for one 4-bit group. Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;
    p  = x | y;
    g  = x & y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, x ^ y ^ {c3, c2, c1, ci}};
  endfunction

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    // Bits [LO, HI) of the result are produced in this stage; operand bits
    // arrive already shifted so this stage's groups sit at the bottom of a_in.
    localparam int LO   = STAGE_BITS * k;
    localparam int HI   = (LO + STAGE_BITS > WIDTH) ? WIDTH : LO + STAGE_BITS;
    localparam int NB   = HI - LO;
    localparam int NG   = NB / 4;
    localparam bit LAST = (k == NUM_STAGES - 1);

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in;
    logic                v_in;
    logic [NB-1:0]       s_new;
    logic                c_out;
    logic [4:0]          grp;
    logic                carry;
    logic [HI-1:0]       s_next;
    logic [HI-1:0]       s_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign v_in   = in_valid;
      assign s_next = s_new;
    end else begin : g_next
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_new, g_stage[k-1].s_q};
    end

    // Groups inside one stage ripple their carries combinationally.
    always_comb begin
      carry = c_in;
      s_new = '0;
      grp   = '0;
      for (int j = 0; j < NG; j++) begin
        grp              = cla4(a_in[4*j +: 4], b_in[4*j +: 4], carry);
        s_new[4*j +: 4]  = grp[3:0];
        carry            = grp[4];
      end
      c_out = carry;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
        s_q <= s_next;
        c_q <= c_out;
      end
    end

    if (!LAST) begin : g_fwd
      // Operand bits not yet consumed travel with the partial result.
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[WIDTH-LO-1:NB];
          b_q <= b_in[WIDTH-LO-1:NB];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as a^b^sum at that bit.
      logic ovf_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= a_in[NB-1] ^ b_in[NB-1] ^ s_new[NB-1] ^ c_out;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].v_q;
  assign sum       = g_stage[NUM_STAGES-1].s_q;
  assign cout      = g_stage[NUM_STAGES-1].c_q;
  assign ovf       = g_stage[NUM_STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_adder_pipe
//   Self-checking bench for cla_adder_pipe. Three instances share the input
//   handshake signals: 16-bit/1 group per stage (latency 4), 32-bit/3 groups
//   per stage (latency 3, uneven last stage) and 4-bit/2 groups per stage
//   (single stage, latency 1). Expected results come from integer arithmetic
//   on A, B and cin.
// ---------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int L16 = 4;
  localparam int L32 = 3;
  localparam int L4  = 1;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic [31:0] a_w, b_w;

  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic        in_ready_w, out_valid_w, cout_w, ovf_w;
  logic [31:0] sum_w;
  logic        in_ready_n, out_valid_n, cout_n, ovf_n;
  logic [3:0]  sum_n;

  int checks = 0;
  int errors = 0;

  exp_t q16[$];
  exp_t q32[$];
  exp_t q4[$];

  cla_adder_pipe #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  cla_adder_pipe #(.WIDTH(32), .GROUPS_PER_STAGE(3)) dut_w (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .cin(cin), .sub(sub), .out_valid(out_valid_w),
    .out_ready(out_ready), .sum(sum_w), .cout(cout_w), .ovf(ovf_w));

  cla_adder_pipe #(.WIDTH(4), .GROUPS_PER_STAGE(2)) dut_n (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_n),
    .a(a_w[3:0]), .b(b_w[3:0]), .cin(cin), .sub(sub), .out_valid(out_valid_n),
    .out_ready(out_ready), .sum(sum_n), .cout(cout_n), .ovf(ovf_n));

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input longint av, input longint bv,
                                 input logic ci, input logic sb, input int w);
    longint m, t, sa, sbv, r, cv;
    exp_t   e;
    m   = longint'(1) << w;
    cv  = ci ? 1 : 0;
    sa  = (av >= m / 2) ? av - m : av;
    sbv = (bv >= m / 2) ? bv - m : bv;
    if (sb) begin
      t    = av - bv - cv;
      r    = sa - sbv - cv;
      e.co = (t >= 0);
    end else begin
      t    = av + bv + cv;
      r    = sa + sbv + cv;
      e.co = (t >= m);
    end
    e.s  = 32'(((t % m) + m) % m);
    e.ov = (r >= m / 2) || (r < -(m / 2));
    return e;
  endfunction

  task automatic do_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q16.delete();
    q32.delete();
    q4.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0; a_w = '0; b_w = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid_w !== 1'b0 || out_valid_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_other_valid: got %b/%b expected 0/0", out_valid_w, out_valid_n); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va[3], vb[3], vs[3];
    logic        vc[3], vsub[3], vco[3], vov[3];
    va   = '{16'hFFFF, 16'h8000, 16'h0FFF};
    vb   = '{16'h0001, 16'h0001, 16'h0000};
    vc   = '{1'b0, 1'b0, 1'b1};
    vsub = '{1'b0, 1'b1, 1'b0};
    vs   = '{16'h0000, 16'h7FFF, 16'h1000};
    vco  = '{1'b1, 1'b1, 1'b0};
    vov  = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      a = va[t]; b = vb[t]; cin = vc[t]; sub = vsub[t]; in_valid = 1'b1;
      @(posedge clk);
      for (int i = 1; i < L16; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL directed_early_%0d: out_valid %b after %0d edges, expected 0", t, out_valid, i); end
        @(posedge clk);
      end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL directed_latency_%0d: out_valid %b expected 1", t, out_valid); end
      checks++; if (sum !== vs[t]) begin errors++; $display("[TB] FAIL directed_sum_%0d: got %h expected %h", t, sum, vs[t]); end
      checks++; if (cout !== vco[t]) begin errors++; $display("[TB] FAIL directed_cout_%0d: got %b expected %b", t, cout, vco[t]); end
      checks++; if (ovf !== vov[t]) begin errors++; $display("[TB] FAIL directed_ovf_%0d: got %b expected %b", t, ovf, vov[t]); end
    end
  endtask

  task automatic test_back_to_back();
    int   first = -1;
    int   got   = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int c = 0; c < 8 + L16 + 6; c++) begin
      @(negedge clk);
      if (c < 8) begin
        a = 16'(c * 'h1111); b = 16'h0F0F; sub = c[0]; cin = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        checks++; if (c != first + got) begin errors++; $display("[TB] FAIL b2b_gap: result %0d at cycle %0d expected cycle %0d", got, c, first + got); end
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra: unexpected result sum=%h", sum);
        end else begin
          e = q16.pop_front();
          if ({sum, cout, ovf} !== {e.s[15:0], e.co, e.ov}) begin
            errors++;
            $display("[TB] FAIL b2b_result_%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", got, sum, cout, ovf, e.s[15:0], e.co, e.ov);
          end
        end
        got++;
      end
      if (in_valid && in_ready) q16.push_back(model(longint'(a), longint'(b), cin, sub, 16));
      @(posedge clk);
    end
    checks++; if (got != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d results expected 8", got); end
    checks++; if (first != L16) begin errors++; $display("[TB] FAIL b2b_first: first result at cycle %0d expected %0d", first, L16); end
  endtask

  task automatic test_backpressure();
    int          pushed = 0;
    int          popped = 0;
    logic [17:0] held;
    exp_t        e;
    held = '0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      in_valid  = (c < 12);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (c >= 6 && c < 11) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid_c%0d: got %b expected 1", c, out_valid); end
        if (c == 6) begin
          held = {sum, cout, ovf};
        end else begin
          checks++; if ({sum, cout, ovf} !== held) begin errors++; $display("[TB] FAIL bp_hold_c%0d: got %h expected %h", c, {sum, cout, ovf}, held); end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("[TB] FAIL bp_extra: unexpected result sum=%h", sum);
        end else begin
          e = q16.pop_front();
          if ({sum, cout, ovf} !== {e.s[15:0], e.co, e.ov}) begin
            errors++;
            $display("[TB] FAIL bp_result_%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", popped, sum, cout, ovf, e.s[15:0], e.co, e.ov);
          end
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        q16.push_back(model(longint'(a), longint'(b), cin, sub, 16));
        pushed++;
      end
      @(posedge clk);
    end
    checks++; if (pushed != 7) begin errors++; $display("[TB] FAIL bp_accepted: got %0d transfers expected 7", pushed); end
    checks++; if (popped != pushed || q16.size() != 0) begin errors++; $display("[TB] FAIL bp_drain: got %0d results expected %0d", popped, pushed); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = 16'h1234 + 16'(c); b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_valid: got %b expected 1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0) begin errors++; $display("[TB] FAIL rst_mid_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_flags: got cout=%b ovf=%b expected 0/0", cout, ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q16.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
      @(posedge clk);
    end
    checks++; if (stale != 0) begin errors++; $display("[TB] FAIL rst_mid_stale: got %0d stale results expected 0", stale); end
  endtask

  task automatic test_latency_sweep();
    int   lat16 = 0;
    int   lat32 = 0;
    int   lat4  = 0;
    exp_t e;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; a_w = 32'h89AB_CDEF; b_w = 32'h0123_4567;
    cin = 1'b1; sub = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid && lat16 == 0) lat16 = k;
      if (out_valid_n && lat4 == 0) lat4 = k;
      if (out_valid_w && lat32 == 0) begin
        lat32 = k;
        e = model(longint'(a_w), longint'(b_w), cin, sub, 32);
        checks++; if ({sum_w, cout_w, ovf_w} !== {e.s, e.co, e.ov}) begin errors++; $display("[TB] FAIL sweep_w32_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", sum_w, cout_w, ovf_w, e.s, e.co, e.ov); end
      end
      @(posedge clk);
    end
    checks++; if (lat16 != L16) begin errors++; $display("[TB] FAIL sweep_lat_w16_g1: got %0d expected %0d", lat16, L16); end
    checks++; if (lat32 != L32) begin errors++; $display("[TB] FAIL sweep_lat_w32_g3: got %0d expected %0d", lat32, L32); end
    checks++; if (lat4 != L4) begin errors++; $display("[TB] FAIL sweep_lat_w4_g2: got %0d expected %0d", lat4, L4); end
  endtask

  task automatic test_random();
    localparam int N = 4000;
    logic [17:0] hold_val;
    logic        hold16;
    exp_t        e;
    do_reset();
    hold16   = 1'b0;
    hold_val = '0;
    for (int c = 0; c < N + 12; c++) begin
      @(negedge clk);
      if (c < N) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a_w = $urandom; b_w = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      a = a_w[15:0]; b = b_w[15:0];
      #1;
      if (hold16) begin
        checks++; if ({sum, cout, ovf} !== hold_val) begin errors++; $display("[TB] FAIL rand_hold_c%0d: got %h expected %h", c, {sum, cout, ovf}, hold_val); end
      end
      hold16   = out_valid && !out_ready;
      hold_val = {sum, cout, ovf};
      if (out_valid && out_ready) begin
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("[TB] FAIL rand_w16_extra: unexpected result at cycle %0d", c);
        end else begin
          e = q16.pop_front();
          if ({sum, cout, ovf} !== {e.s[15:0], e.co, e.ov}) begin
            errors++; $display("[TB] FAIL rand_w16_c%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", c, sum, cout, ovf, e.s[15:0], e.co, e.ov);
          end
        end
      end
      if (in_valid && in_ready) q16.push_back(model(longint'(a), longint'(b), cin, sub, 16));
      if (out_valid_w && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++; $display("[TB] FAIL rand_w32_extra: unexpected result at cycle %0d", c);
        end else begin
          e = q32.pop_front();
          if ({sum_w, cout_w, ovf_w} !== {e.s, e.co, e.ov}) begin
            errors++; $display("[TB] FAIL rand_w32_c%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", c, sum_w, cout_w, ovf_w, e.s, e.co, e.ov);
          end
        end
      end
      if (in_valid && in_ready_w) q32.push_back(model(longint'(a_w), longint'(b_w), cin, sub, 32));
      if (out_valid_n && out_ready) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("[TB] FAIL rand_w4_extra: unexpected result at cycle %0d", c);
        end else begin
          e = q4.pop_front();
          if ({sum_n, cout_n, ovf_n} !== {e.s[3:0], e.co, e.ov}) begin
            errors++; $display("[TB] FAIL rand_w4_c%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b", c, sum_n, cout_n, ovf_n, e.s[3:0], e.co, e.ov);
          end
        end
      end
      if (in_valid && in_ready_n) q4.push_back(model(longint'(a_w[3:0]), longint'(b_w[3:0]), cin, sub, 4));
      @(posedge clk);
    end
    checks++; if (q16.size() != 0) begin errors++; $display("[TB] FAIL rand_w16_lost: %0d results never appeared", q16.size()); end
    checks++; if (q32.size() != 0) begin errors++; $display("[TB] FAIL rand_w32_lost: %0d results never appeared", q32.size()); end
    checks++; if (q4.size() != 0) begin errors++; $display("[TB] FAIL rand_w4_lost: %0d results never appeared", q4.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_latency_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
